// File: rtl/cause_control_mux.sv
`default_nettype none
// ============================================================================
// Module      : cause_control_mux
// Description : Selects the exception-cause code that feeds the Cause
//               register from three entries using a 2-bit control field.
//               Select 2'b11 is illegal: it yields all zeros on the output
//               and sets a sticky illegal_sel flag, cleared only by reset.
//               Optional build macro CAUSECONTROLMUX_OUTREG_EN registers
//               the output (1-cycle latency, synchronous reset to zero).
// Revision    : 1.0 - initial release
// ============================================================================
module cause_control_mux #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] entry0,
    input  logic [WIDTH-1:0] entry1,
    input  logic [WIDTH-1:0] entry2,
    input  logic [1:0]       controlSingal,
    output logic [WIDTH-1:0] out,
    output logic             illegal_sel
);

    localparam logic [1:0] c_SEL_ENTRY0  = 2'b00;
    localparam logic [1:0] c_SEL_ENTRY1  = 2'b01;
    localparam logic [1:0] c_SEL_ENTRY2  = 2'b10;
    localparam logic [1:0] c_SEL_ILLEGAL = 2'b11;

    logic [WIDTH-1:0] w_selected;
    logic             r_illegal_sel;

    // Select the cause code; the illegal encoding yields all zeros.
    always_comb begin
        w_selected = '0;
        case (controlSingal)
            c_SEL_ENTRY0: w_selected = entry0;
            c_SEL_ENTRY1: w_selected = entry1;
            c_SEL_ENTRY2: w_selected = entry2;
            default:      w_selected = '0;
        endcase
    end

    // Sticky illegal-select flag; reset has priority over a set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_illegal_sel <= 1'b0;
        end else if (controlSingal == c_SEL_ILLEGAL) begin
            r_illegal_sel <= 1'b1;
        end
    end

    assign illegal_sel = r_illegal_sel;

`ifdef CAUSECONTROLMUX_OUTREG_EN
    logic [WIDTH-1:0] r_out;

    // Registered output stage: one cycle of latency, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= '0;
        end else begin
            r_out <= w_selected;
        end
    end

    assign out = r_out;
`else
    // Purely combinational output; reset does not touch this path.
    assign out = w_selected;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cause_control_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_cause_control_mux
// Description : Self-checking bench for cause_control_mux. Table-driven
//               select/entry vectors plus hand-written sequences for the
//               sticky illegal_sel flag and reset interaction. Follows the
//               output latency of the CAUSECONTROLMUX_OUTREG_EN build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cause_control_mux;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] entry0;
    logic [WIDTH-1:0] entry1;
    logic [WIDTH-1:0] entry2;
    logic [1:0]       controlSingal;
    logic [WIDTH-1:0] out;
    logic             illegal_sel;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [WIDTH-1:0] e0;
        logic [WIDTH-1:0] e1;
        logic [WIDTH-1:0] e2;
        logic [1:0]       sel;
        logic [WIDTH-1:0] exp_out;
    } vec_t;

    vec_t vecs [8];

    cause_control_mux #(.WIDTH(WIDTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .entry0        (entry0),
        .entry1        (entry1),
        .entry2        (entry2),
        .controlSingal (controlSingal),
        .out           (out),
        .illegal_sel   (illegal_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check8(input string name, input logic [WIDTH-1:0] act,
                          input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Wait until the output reflects inputs driven at the last falling edge.
    task automatic settle();
`ifdef CAUSECONTROLMUX_OUTREG_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    // Cross one rising edge and sample shortly after it.
    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{8'hFF, 8'h0F, 8'h01, 2'b00, 8'hFF};
        vecs[1] = '{8'hFF, 8'h0F, 8'h01, 2'b01, 8'h0F};
        vecs[2] = '{8'hFF, 8'h0F, 8'h01, 2'b10, 8'h01};
        vecs[3] = '{8'hFF, 8'hA5, 8'h01, 2'b01, 8'hA5};
        vecs[4] = '{8'h3C, 8'hC3, 8'h5A, 2'b00, 8'h3C};
        vecs[5] = '{8'h3C, 8'hC3, 8'h5A, 2'b01, 8'hC3};
        vecs[6] = '{8'h3C, 8'hC3, 8'h5A, 2'b10, 8'h5A};
        vecs[7] = '{8'h00, 8'h80, 8'h7E, 2'b10, 8'h7E};

        // Reset for one edge with the first test-plan entries applied.
        reset         = 1'b1;
        entry0        = 8'hFF;
        entry1        = 8'h0F;
        entry2        = 8'h01;
        controlSingal = 2'b00;
        edge_step();
        check1("reset_illegal", illegal_sel, 1'b0);
`ifdef CAUSECONTROLMUX_OUTREG_EN
        check8("reset_out_reg", out, 8'h00);
`else
        check8("reset_out_comb", out, 8'hFF);
`endif
        @(negedge clk);
        reset = 1'b0;
        settle();
        check8("post_reset_out", out, 8'hFF);
        check1("post_reset_illegal", illegal_sel, 1'b0);

        // Legal select vectors; illegal_sel must stay clear throughout.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            entry0        = vecs[i].e0;
            entry1        = vecs[i].e1;
            entry2        = vecs[i].e2;
            controlSingal = vecs[i].sel;
            settle();
            check8($sformatf("vec%0d_out", i), out, vecs[i].exp_out);
            check1($sformatf("vec%0d_illegal", i), illegal_sel, 1'b0);
        end

        // Entry change alone, select held at 01.
        @(negedge clk);
        entry0 = 8'hFF; entry1 = 8'h0F; entry2 = 8'h01; controlSingal = 2'b01;
        settle();
        check8("hold01_before", out, 8'h0F);
        @(negedge clk);
        entry1 = 8'hA5;
        settle();
        check8("hold01_follow", out, 8'hA5);

        // Illegal select for one edge, then back to 00.
        @(negedge clk);
        controlSingal = 2'b11;
`ifndef CAUSECONTROLMUX_OUTREG_EN
        #1;
        check8("sel11_out_comb", out, 8'h00);
        check1("sel11_illegal_pre_edge", illegal_sel, 1'b0);
`endif
        edge_step();
        check1("sel11_illegal_set", illegal_sel, 1'b1);
`ifdef CAUSECONTROLMUX_OUTREG_EN
        check8("sel11_out_reg", out, 8'h00);
`endif
        @(negedge clk);
        controlSingal = 2'b00;
        settle();
        check8("after11_out", out, 8'hFF);
        check1("after11_illegal_sticky", illegal_sel, 1'b1);
        edge_step();
        edge_step();
        check1("illegal_sticky_later", illegal_sel, 1'b1);

        // Reset clears the sticky flag.
        @(negedge clk);
        reset = 1'b1;
        edge_step();
        check1("reset_clears_illegal", illegal_sel, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Set the flag again, then reset together with select 11.
        @(negedge clk);
        controlSingal = 2'b11;
        edge_step();
        check1("reset_set_again", illegal_sel, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        edge_step();
        check1("reset_wins_from1", illegal_sel, 1'b0);
        edge_step();
        check1("reset_wins_held", illegal_sel, 1'b0);

        // Reset with select 00, entry0 FF: output behaviour under reset.
        @(negedge clk);
        controlSingal = 2'b00;
        entry0        = 8'hFF;
        edge_step();
`ifdef CAUSECONTROLMUX_OUTREG_EN
        check8("reset_out_zero", out, 8'h00);
`else
        check8("reset_no_effect_out", out, 8'hFF);
`endif
        @(negedge clk);
        reset = 1'b0;
        edge_step();
        check8("release_out", out, 8'hFF);
        check1("release_illegal", illegal_sel, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cause_control_mux.md
Name: cause_control_mux

Overview:
- Selects the 8-bit exception-cause code that feeds the processor's Cause register.
- Chooses among three constant/derived cause encodings using a 2-bit control field from the main control unit.
- Sits between the control unit and the Cause register write port.
- Also tracks illegal select values in a sticky, clocked status flag so verification and debug can detect control-unit faults.

Parameters:
- WIDTH, 8, bit width of each entry and of the output.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- entry0  input  WIDTH  cause code selected when controlSingal = 2'b00.
- entry1  input  WIDTH  cause code selected when controlSingal = 2'b01.
- entry2  input  WIDTH  cause code selected when controlSingal = 2'b10.
- controlSingal  input  2  select field from the control unit.
- out  output  WIDTH  selected cause code.
- illegal_sel  output  1  sticky flag; set once controlSingal = 2'b11 has been sampled.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset), sampled only on the rising edge of clk.
- Selection, combinational in the default build:
  - 00 -> entry0
  - 01 -> entry1
  - 10 -> entry2
  - 11 -> all zeros
- The out path depends only on controlSingal and the entries. It is never X for a known select. No latches are permitted.
- In the default build, out responds to input changes with zero clock latency. reset does not affect out.
- illegal_sel register, evaluated at each rising clk edge:
  - reset = 1: illegal_sel <= 0. Reset has priority over everything else.
  - else if controlSingal == 2'b11: illegal_sel <= 1.
  - else: hold.
- Once set, illegal_sel stays 1 until a reset. A later legal select does not clear it.
- illegal_sel is 0 after reset and at least one clock edge. Its value before the first reset edge is undefined.
- If reset is asserted in the same cycle as controlSingal = 11, reset wins and illegal_sel = 0.
- Entry widths always match WIDTH. There is no truncation or extension.

Optional Feature:
- Macro: CAUSECONTROLMUX_OUTREG_EN.
- Defined:
  - out is registered: out <= selected value on each rising clk edge, giving 1-cycle latency from controlSingal/entries to out.
  - Synchronous reset drives out to 0.
  - Select 11 registers zeros.
  - illegal_sel behaviour is unchanged.
- Not defined:
  - out is purely combinational as described in Behaviour.
  - No output register exists.

Test Plan:
- Apply reset for 1 cycle, then deassert it; entry0=FF, entry1=0F, entry2=01, controlSingal=00 -> out=FF, illegal_sel=0.
- Same entries; step controlSingal 00 -> 01 -> 10 at 10 us intervals -> out=FF, then 0F, then 01, combinationally (one cycle later with CAUSECONTROLMUX_OUTREG_EN defined).
- Hold controlSingal=01 and change entry1 from 0F to A5 -> out follows to A5 without any other input change.
- controlSingal=11 for one clock edge, then 00 -> out=00 while the select is 11; illegal_sel=1 after that edge and remains 1 with select 00.
- Assert reset while illegal_sel=1 -> illegal_sel=0 after the edge. Repeat with reset and controlSingal=11 in the same cycle -> illegal_sel=0.
- With CAUSECONTROLMUX_OUTREG_EN defined, assert reset with controlSingal=00 and entry0=FF -> out=00 after the edge, then out=FF one edge after reset is released.
